// File: rtl/rib_arbiter.sv
// Two masters (core M0, loader/debug M1) onto four slaves. Writes are combinational; read data comes back 1 cycle later.
// A master that does not own the bus waits (core via rib_hold_flag_o, M1 via m1_gnt_o). RIB_TIMEOUT_EN adds forced release and bus_err_o.
module rib_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned SEL_LSB     = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_rd_req_i,
    input  logic [31:0] m0_rd_addr_i,
    output logic [31:0] m0_rd_data_o,
    input  logic        m0_wr_req_i,
    input  logic        m0_wr_en_i,
    input  logic [31:0] m0_wr_addr_i,
    input  logic [31:0] m0_wr_data_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_gnt_o,
    output logic [31:0] s0_rd_addr_o,
    input  logic [31:0] s0_rd_data_i,
    output logic        s0_wr_en_o,
    output logic [31:0] s0_wr_addr_o,
    output logic [31:0] s0_wr_data_o,
    output logic [31:0] s1_rd_addr_o,
    input  logic [31:0] s1_rd_data_i,
    output logic        s1_wr_en_o,
    output logic [31:0] s1_wr_addr_o,
    output logic [31:0] s1_wr_data_o,
    output logic [31:0] s2_rd_addr_o,
    input  logic [31:0] s2_rd_data_i,
    output logic        s2_wr_en_o,
    output logic [31:0] s2_wr_addr_o,
    output logic [31:0] s2_wr_data_o,
    output logic [31:0] s3_rd_addr_o,
    input  logic [31:0] s3_rd_data_i,
    output logic        s3_wr_en_o,
    output logic [31:0] s3_wr_addr_o,
    output logic [31:0] s3_wr_data_o,
    output logic        rib_hold_flag_o,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

    state_t      state_q, state_d;
    logic        m0_req, own_m0, own_m1;
    logic        force_q, tmo_hit;
    logic        rd_go, wr_go;
    logic        rd_vld_q, rd_m1_q;
    logic [3:0]  rd_idx_q, wr_idx;
    logic [31:0] rd_addr, wr_addr, wr_data, rd_mux;

    assign m0_req = m0_rd_req_i | m0_wr_req_i;

    // In IDLE the grant is combinational so a lone requester loses no cycle.
    always_comb begin
        own_m0  = 1'b0;
        own_m1  = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!force_q) begin
                    if (m1_req_i) begin
                        own_m1  = 1'b1;
                        state_d = OWN_M1;
                    end else if (m0_req) begin
                        own_m0  = 1'b1;
                        state_d = OWN_M0;
                    end
                end
            end
            OWN_M0: begin
                own_m0 = 1'b1;
                if (!m0_req) state_d = m1_req_i ? OWN_M1 : IDLE;
            end
            OWN_M1: begin
                own_m1 = 1'b1;
                if (!m1_req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

`ifdef RIB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // Fires on the TIMEOUT_CYC-th consecutive owned cycle; the following cycle is a forced, ownerless IDLE.
    assign tmo_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == IDLE || tmo_hit) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            force_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= tmo_hit;
            err_q   <= err_q | tmo_hit;
        end
    end

    assign bus_err_o = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign force_q   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    assign rd_addr = own_m1 ? m1_addr_i  : m0_rd_addr_i;
    assign wr_addr = own_m1 ? m1_addr_i  : m0_wr_addr_i;
    assign wr_data = own_m1 ? m1_wdata_i : m0_wr_data_i;
    assign wr_idx  = wr_addr[SEL_LSB +: 4];
    assign rd_go   = (own_m0 & m0_rd_req_i) | (own_m1 & m1_req_i & ~m1_we_i);
    assign wr_go   = rst_n & ((own_m0 & m0_wr_req_i & m0_wr_en_i) | (own_m1 & m1_req_i & m1_we_i));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_vld_q <= 1'b0;
            rd_m1_q  <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_go;
            rd_m1_q  <= own_m1;
            rd_idx_q <= rd_addr[SEL_LSB +: 4];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx_q)
            4'd0:    rd_mux = s0_rd_data_i;
            4'd1:    rd_mux = s1_rd_data_i;
            4'd2:    rd_mux = s2_rd_data_i;
            4'd3:    rd_mux = s3_rd_data_i;
            default: rd_mux = '0;
        endcase
    end

    assign m0_rd_data_o = (rst_n && rd_vld_q && !rd_m1_q) ? rd_mux : '0;
    assign m1_rdata_o   = (rst_n && rd_vld_q &&  rd_m1_q) ? rd_mux : '0;

    assign s0_rd_addr_o = rd_addr;
    assign s1_rd_addr_o = rd_addr;
    assign s2_rd_addr_o = rd_addr;
    assign s3_rd_addr_o = rd_addr;
    assign s0_wr_addr_o = wr_addr;
    assign s1_wr_addr_o = wr_addr;
    assign s2_wr_addr_o = wr_addr;
    assign s3_wr_addr_o = wr_addr;
    assign s0_wr_data_o = wr_data;
    assign s1_wr_data_o = wr_data;
    assign s2_wr_data_o = wr_data;
    assign s3_wr_data_o = wr_data;
    assign s0_wr_en_o   = wr_go & (wr_idx == 4'd0);
    assign s1_wr_en_o   = wr_go & (wr_idx == 4'd1);
    assign s2_wr_en_o   = wr_go & (wr_idx == 4'd2);
    assign s3_wr_en_o   = wr_go & (wr_idx == 4'd3);

    assign rib_hold_flag_o = m0_req & ~own_m0;
    assign m1_gnt_o        = own_m1;
endmodule

// File: tb/tb_rib_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a bus-ownership model.
module tb_rib_arbiter;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_rd_req_i, m0_wr_req_i, m0_wr_en_i, m1_req_i, m1_we_i;
    logic [31:0] m0_rd_addr_i, m0_wr_addr_i, m0_wr_data_i, m1_addr_i, m1_wdata_i;
    logic [31:0] m0_rd_data_o, m1_rdata_o;
    logic        m1_gnt_o, rib_hold_flag_o, bus_err_o;
    logic [31:0] s0_rd_addr_o, s1_rd_addr_o, s2_rd_addr_o, s3_rd_addr_o;
    logic [31:0] s0_wr_addr_o, s1_wr_addr_o, s2_wr_addr_o, s3_wr_addr_o;
    logic [31:0] s0_wr_data_o, s1_wr_data_o, s2_wr_data_o, s3_wr_data_o;
    logic        s0_wr_en_o, s1_wr_en_o, s2_wr_en_o, s3_wr_en_o;
    logic [31:0] sd [4];
    logic [3:0]  wen;

    int checks = 0;
    int failures = 0;

    // Model: owner state 0=none, 1=M0, 2=M1; one pending read slot.
    int m_state = 0, m_cnt = 0, m_ri = 0;
    bit m_force = 0, m_err = 0, m_rv = 0, m_rw = 0;

    always #5 clk = ~clk;

    assign wen = {s3_wr_en_o, s2_wr_en_o, s1_wr_en_o, s0_wr_en_o};

    rib_arbiter #(.TIMEOUT_CYC(TMO), .SEL_LSB(28)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_req_i(m0_rd_req_i), .m0_rd_addr_i(m0_rd_addr_i), .m0_rd_data_o(m0_rd_data_o),
        .m0_wr_req_i(m0_wr_req_i), .m0_wr_en_i(m0_wr_en_i), .m0_wr_addr_i(m0_wr_addr_i),
        .m0_wr_data_i(m0_wr_data_i),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(m1_rdata_o), .m1_gnt_o(m1_gnt_o),
        .s0_rd_addr_o(s0_rd_addr_o), .s0_rd_data_i(sd[0]), .s0_wr_en_o(s0_wr_en_o),
        .s0_wr_addr_o(s0_wr_addr_o), .s0_wr_data_o(s0_wr_data_o),
        .s1_rd_addr_o(s1_rd_addr_o), .s1_rd_data_i(sd[1]), .s1_wr_en_o(s1_wr_en_o),
        .s1_wr_addr_o(s1_wr_addr_o), .s1_wr_data_o(s1_wr_data_o),
        .s2_rd_addr_o(s2_rd_addr_o), .s2_rd_data_i(sd[2]), .s2_wr_en_o(s2_wr_en_o),
        .s2_wr_addr_o(s2_wr_addr_o), .s2_wr_data_o(s2_wr_data_o),
        .s3_rd_addr_o(s3_rd_addr_o), .s3_rd_data_i(sd[3]), .s3_wr_en_o(s3_wr_en_o),
        .s3_wr_addr_o(s3_wr_addr_o), .s3_wr_data_o(s3_wr_data_o),
        .rib_hold_flag_o(rib_hold_flag_o), .bus_err_o(bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eff_owner();
        if (m_state != 0) return m_state;
        if (m_force) return 0;
        if (m1_req_i) return 2;
        if (m0_rd_req_i || m0_wr_req_i) return 1;
        return 0;
    endfunction

    task automatic model_update(input int e);
        int nxt;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_force = 0; m_err = 0; m_rv = 0;
            return;
        end
        m_rv = (e == 1 && m0_rd_req_i) || (e == 2 && m1_req_i && !m1_we_i);
        m_rw = (e == 2);
        m_ri = (e == 2) ? int'(m1_addr_i[31:28]) : int'(m0_rd_addr_i[31:28]);
        if (m_state == 0)      nxt = m_force ? 0 : e;
        else if (m_state == 1) nxt = (m0_rd_req_i || m0_wr_req_i) ? 1 : (m1_req_i ? 2 : 0);
        else                   nxt = m1_req_i ? 2 : 0;
        m_force = 0;
`ifdef RIB_TIMEOUT_EN
        if (m_state != 0) begin
            m_cnt++;
            if (m_cnt == TMO) begin
                nxt = 0; m_force = 1; m_err = 1; m_cnt = 0;
            end
        end else begin
            m_cnt = 0;
        end
`endif
        m_state = nxt;
    endtask

    // Called at a negedge with inputs applied; compares, then advances one clock.
    task automatic run_cycle();
        int          e;
        logic [31:0] wa, wd, ra, r0, r1;
        logic [3:0]  ew;
        bit          wgo;
        #1;
        e   = eff_owner();
        wa  = (e == 2) ? m1_addr_i  : m0_wr_addr_i;
        wd  = (e == 2) ? m1_wdata_i : m0_wr_data_i;
        ra  = (e == 2) ? m1_addr_i  : m0_rd_addr_i;
        wgo = rst_n && ((e == 1 && m0_wr_req_i && m0_wr_en_i) || (e == 2 && m1_req_i && m1_we_i));
        ew  = wgo ? (4'b0001 << wa[31:28]) : 4'b0000;
        r0  = (rst_n && m_rv && !m_rw && m_ri < 4) ? sd[m_ri] : 32'h0;
        r1  = (rst_n && m_rv &&  m_rw && m_ri < 4) ? sd[m_ri] : 32'h0;
        chk("wr_en", {28'h0, wen}, {28'h0, ew});
        chk("m0_rdata", m0_rd_data_o, r0);
        chk("m1_rdata", m1_rdata_o, r1);
        if (rst_n) begin
            chk("s0_rd_addr", s0_rd_addr_o, ra);
            chk("s2_rd_addr", s2_rd_addr_o, ra);
            chk("s1_wr_addr", s1_wr_addr_o, wa);
            chk("s3_wr_data", s3_wr_data_o, wd);
            chk("hold", rib_hold_flag_o, (m0_rd_req_i || m0_wr_req_i) && e != 1);
            chk("gnt", m1_gnt_o, e == 2);
            chk("bus_err", bus_err_o, m_err);
        end
        @(posedge clk);
        model_update(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_rd_req_i = 0; m0_wr_req_i = 0; m0_wr_en_i = 0; m1_req_i = 0; m1_we_i = 0;
    endtask

    function automatic logic [31:0] raddr();
        logic [3:0] s;
        s = 4'($urandom_range(0, 5));
        return {s, 28'($urandom)};
    endfunction

    initial begin
        int g;
        bit seen0;
        idle_inputs();
        m0_rd_addr_i = 0; m0_wr_addr_i = 0; m0_wr_data_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
        for (int i = 0; i < 4; i++) sd[i] = 32'h1111_0000 * (i + 1);
        rst_n = 0;
        @(negedge clk);
        run_cycle(); run_cycle();
        rst_n = 1;
        #1;
        chk("rst_gnt", m1_gnt_o, 0);
        chk("rst_err", bus_err_o, 0);
        chk("rst_m0_rdata", m0_rd_data_o, 0);
        run_cycle();

        // Core read of slave 1 returns next cycle
        m0_rd_req_i = 1; m0_rd_addr_i = 32'h1000_0004; sd[1] = 32'hDEAD_BEEF;
        run_cycle();
        m0_rd_req_i = 0;
        #1;
        chk("rd1_data", m0_rd_data_o, 32'hDEAD_BEEF);
        chk("rd1_hold", rib_hold_flag_o, 0);
        run_cycle();
        run_cycle();

        // Simultaneous request: M1 wins, core held until M1 lets go
        m0_rd_req_i = 1; m0_rd_addr_i = 32'h0000_0100; m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h2000_0000;
        #1;
        chk("tie_gnt", m1_gnt_o, 1);
        chk("tie_hold", rib_hold_flag_o, 1);
        run_cycle(); run_cycle();
        m1_req_i = 0;
        run_cycle();
        #1;
        chk("tie_after_gnt", m1_gnt_o, 0);
        chk("tie_after_hold", rib_hold_flag_o, 0);
        run_cycle();
        idle_inputs(); run_cycle(); run_cycle();

        // M1 write to slave 3, then to an unmapped slave
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h3000_0000; m1_wdata_i = 32'h55;
        #1;
        chk("m1wr_wen", {28'h0, wen}, 32'h8);
        chk("m1wr_data", s3_wr_data_o, 32'h55);
        run_cycle();
        m1_req_i = 0;
        #1;
        chk("m1wr_one_cycle", s3_wr_en_o, 0);
        run_cycle(); run_cycle();
        m1_req_i = 1; m1_addr_i = 32'h5000_0000;
        #1;
        chk("unmapped_wen", {28'h0, wen}, 32'h0);
        run_cycle();
        idle_inputs(); run_cycle(); run_cycle();

        // Core reads and writes slave 2 in the same cycle
        m0_rd_req_i = 1; m0_rd_addr_i = 32'h2000_0010;
        m0_wr_req_i = 1; m0_wr_en_i = 1; m0_wr_addr_i = 32'h2000_0020; m0_wr_data_i = 32'hA5A5_0001;
        sd[2] = 32'hCAFE_0002;
        #1;
        chk("dual_wen", s2_wr_en_o, 1);
        chk("dual_rd_addr", s2_rd_addr_o, 32'h2000_0010);
        run_cycle();
        idle_inputs();
        #1;
        chk("dual_rdata", m0_rd_data_o, 32'hCAFE_0002);
        run_cycle(); run_cycle();

        // Reset in the middle of a read abandons it
        m0_rd_req_i = 1; m0_rd_addr_i = 32'h1000_0000; sd[1] = 32'h1234_5678;
        run_cycle();
        idle_inputs(); rst_n = 0;
        run_cycle();
        rst_n = 1;
        #1;
        chk("rst_mid_rdata", m0_rd_data_o, 0);
        run_cycle();

`ifdef RIB_TIMEOUT_EN
        // One combinational grant cycle in IDLE plus TMO owned cycles, then one ownerless cycle
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h0000_0000;
        g = 0; seen0 = 0;
        for (int i = 0; i < 40 && !seen0; i++) begin
            #1;
            if (m1_gnt_o) g++; else seen0 = 1;
            if (!seen0) run_cycle();
        end
        chk("tmo_release_seen", seen0, 1);
        chk("tmo_gnt_cycles", g, TMO + 1);
        chk("tmo_err", bus_err_o, 1);
        run_cycle(); run_cycle();
        #1;
        chk("tmo_err_sticky", bus_err_o, 1);
        run_cycle();
        idle_inputs(); rst_n = 0;
        run_cycle();
        rst_n = 1;
        #1;
        chk("tmo_err_rst", bus_err_o, 0);
        run_cycle();
`else
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h0000_0000;
        for (int i = 0; i < 3 * TMO; i++) run_cycle();
        #1;
        chk("no_tmo_gnt", m1_gnt_o, 1);
        chk("no_tmo_err", bus_err_o, 0);
        run_cycle();
        g = 0; seen0 = 0;
`endif
        idle_inputs(); run_cycle();

        // Random traffic with sticky-ish requests
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 4) == 0) m0_rd_req_i = ~m0_rd_req_i;
            if ($urandom_range(0, 4) == 0) m0_wr_req_i = ~m0_wr_req_i;
            if ($urandom_range(0, 5) == 0) m1_req_i = ~m1_req_i;
            m0_wr_en_i   = 1'($urandom);
            m1_we_i      = 1'($urandom);
            m0_rd_addr_i = raddr();
            m0_wr_addr_i = raddr();
            m1_addr_i    = raddr();
            m0_wr_data_i = $urandom;
            m1_wdata_i   = $urandom;
            for (int i = 0; i < 4; i++) sd[i] = $urandom;
            rst_n = ($urandom_range(0, 99) != 0);
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rib_arbiter.md
RIB_ARBITER -- requirements
Module: rib_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: cycles of continuous ownership before forced release (only with RIB_TIMEOUT_EN).
REQ-002 SHALL have parameter SEL_LSB, default 28: LSB of the 4-bit slave-select field addr[SEL_LSB+3:SEL_LSB].
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports m0_rd_req_i (in, 1), m0_rd_addr_i (in, 32) and m0_rd_data_o (out, 32): core read request, address and data.
REQ-006 SHALL have ports m0_wr_req_i (in, 1), m0_wr_en_i (in, 1), m0_wr_addr_i (in, 32) and m0_wr_data_i (in, 32): core write request, strobe, address and data.
REQ-007 SHALL have ports m1_req_i (in, 1), m1_we_i (in, 1), m1_addr_i (in, 32), m1_wdata_i (in, 32), m1_rdata_o (out, 32) and m1_gnt_o (out, 1): loader/debug master.
REQ-008 SHALL have, for each N in 0..3, ports sN_rd_addr_o (out, 32), sN_rd_data_i (in, 32), sN_wr_en_o (out, 1), sN_wr_addr_o (out, 32) and sN_wr_data_o (out, 32).
REQ-009 SHALL have port rib_hold_flag_o, output, 1: pipeline hold to core.
REQ-010 SHALL have port bus_err_o, output, 1: sticky timeout error.

Function
REQ-011 SHALL decode slave index = addr[SEL_LSB+3:SEL_LSB]; values 0-3 are mapped; 4-15 are unmapped: writes dropped, reads return 0.
REQ-012 SHALL implement FSM states IDLE, OWN_M0, OWN_M1; m0 requesting = m0_rd_req_i|m0_wr_req_i.
REQ-013 SHALL compute effective owner: in IDLE, combinationally M1 if m1_req_i, else M0 if m0 requesting, else none; in OWN_Mx, owner is Mx.
REQ-014 SHALL transition IDLE->OWN_M1 on m1_req_i (priority over m0), else IDLE->OWN_M0 on m0 requesting.
REQ-015 SHALL, in OWN_M0, hold while m0 requesting; when it drops, go OWN_M1 if m1_req_i, else IDLE.
REQ-016 SHALL, in OWN_M1, hold while m1_req_i; when it drops, go IDLE.
REQ-017 SHALL route the owner's write to the decoded slave: sN_wr_en_o=1 only for owner write (m0_wr_req_i&m0_wr_en_i or m1_req_i&m1_we_i) and index match; address/data are forwarded to all slaves.
REQ-018 SHALL, for M0, drive the read and write ports independently in the same cycle, including to the same slave.
REQ-019 SHALL register read owner and slave index on each granted read; read data is returned exactly 1 cycle later, muxed by the registered index; the non-owner's rdata is 0.
REQ-020 SHALL drive rib_hold_flag_o=1 combinationally whenever m0 is requesting and the effective owner is not M0.
REQ-021 SHALL drive m1_gnt_o=1 exactly when the effective owner is M1.

Reset
REQ-022 SHALL, with rst_n low at a clk edge, set FSM=IDLE, read registers cleared, timeout counter=0 and bus_err_o=0; all write enables and read data 0 while rst_n is low.
REQ-023 SHALL abandon any in-flight read on reset mid-transfer: rdata is 0 on the first cycle after release.

Configuration
REQ-024 SHALL, with RIB_TIMEOUT_EN defined, count consecutive cycles in OWN_M0/OWN_M1; on reaching TIMEOUT_CYC, force IDLE with no owner for 1 cycle, set bus_err_o (cleared only by reset) and clear the counter; the counter clears on any return to IDLE.
REQ-025 SHALL, without RIB_TIMEOUT_EN, have no counter, tie bus_err_o=0 and never force release.

Verification
REQ-026 SHALL cover: m0_rd_req_i=1, addr=0x1000_0004, s1_rd_data_i=0xDEADBEEF -> next cycle m0_rd_data_o=0xDEADBEEF, rib_hold_flag_o=0.
REQ-027 SHALL cover: m0 and m1 request in the same IDLE cycle -> m1_gnt_o=1, rib_hold_flag_o=1; after m1_req_i drops, owner becomes M0 and hold clears.
REQ-028 SHALL cover: m1 write to 0x3000_0000 data 0x55 -> s3_wr_en_o=1 for 1 cycle with wr_data 0x55; a write to 0x5000_0000 gives all sN_wr_en_o=0.
REQ-029 SHALL cover: M0 reads slave 2 and writes slave 2 in the same cycle -> both s2 strobes are active.
REQ-030 SHALL cover: with RIB_TIMEOUT_EN and TIMEOUT_CYC=8, m1_req_i held high -> after 8 cycles, 1 cycle with no owner and bus_err_o=1 and sticky; rst_n low -> bus_err_o=0.
